// File: rtl/framebuffer_writer.sv
// framebuffer_writer: decimates a raster camera pixel stream 2:1 in both axes onto a framebuffer write port
// Ports: cam_clk_25/reset (async, active-high); enable arms capture at sof;
//   pix_valid/pix_data/pix_sof/pix_eol source stream (no backpressure);
//   wr_en/wr_addr/wr_data framebuffer write port (1-cycle latency);
//   busy (in CAPTURE), frame_done/frame_err one-cycle pulses, frame_count completed frames.
module framebuffer_writer #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  cam_clk_25,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pix_valid,
  input  logic [1:0]            pix_data,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]            wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [7:0]            frame_count
);
  typedef enum logic {WAIT_SOF, CAPTURE} state_t;
  state_t state, state_nxt;
  logic [9:0] x_cnt, cx, x_nxt;
  logic [8:0] y_cnt, cy, y_nxt;
  logic [ADDR_WIDTH-1:0] line_base, cb, base_nxt, addr;
  logic start, active, last_x, short_err, long_err, line_end, frame_end, err, done, write;
  // A sof pixel with enable set is processed as pixel (0,0) of a fresh frame,
  // whether it arrives while idle or as a restart in the middle of a frame.
  always_comb begin
    start     = pix_valid & pix_sof & enable;
    active    = pix_valid & (start | (state == CAPTURE & ~pix_sof));
    cx        = start ? '0 : x_cnt;
    cy        = start ? '0 : y_cnt;
    cb        = start ? '0 : line_base;
    last_x    = cx == 10'(SRC_WIDTH - 1);
    short_err = active & pix_eol & ~last_x;
    long_err  = active & ~pix_eol & last_x;
    line_end  = active & pix_eol & last_x;
    frame_end = line_end & (cy == 9'(SRC_HEIGHT - 1));
    err       = short_err | long_err | (pix_valid & pix_sof & state == CAPTURE);
    done      = frame_end & ~err;
    write     = active & ~long_err & ~cx[0] & ~cy[0];
    addr      = cb + ADDR_WIDTH'(cx[9:1]);
    state_nxt = ~pix_valid ? state :
                (active & ~short_err & ~long_err & ~frame_end) ? CAPTURE : WAIT_SOF;
    x_nxt     = state_nxt == CAPTURE ? (line_end ? '0 : cx + 10'd1) : '0;
    y_nxt     = state_nxt == CAPTURE ? (line_end ? cy + 9'd1 : cy) : '0;
    // row base advances only after odd source lines, which close a framebuffer row
    base_nxt  = state_nxt == CAPTURE ? (line_end & cy[0] ? cb + ADDR_WIDTH'(FB_WIDTH) : cb) : '0;
  end
  always_ff @(posedge cam_clk_25 or posedge reset)
    if (reset) state <= WAIT_SOF;
    else state <= state_nxt;
  always_ff @(posedge cam_clk_25 or posedge reset)
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_base   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (pix_valid) begin
        x_cnt     <= x_nxt;
        y_cnt     <= y_nxt;
        line_base <= base_nxt;
      end
      wr_en <= write;
      if (write) begin
        wr_addr <= addr;
        wr_data <= pix_data;
      end
      busy        <= state_nxt == CAPTURE;
      frame_done  <= done;
      frame_err   <= err;
      frame_count <= frame_count + 8'(done);
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: directed frames against a linear-position model of the writer on a 16x12 source
module tb_framebuffer_writer;
  localparam int W = 16, H = 12, FBW = 8, FBH = 6;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, pv = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [1:0] pd = '0;
  logic wr_en, busy, frame_done, frame_err;
  logic [16:0] wr_addr;
  logic [1:0] wr_data;
  logic [7:0] frame_count;
  int tot = 0, bad = 0;
  bit chkon = 1'b0;
  bit cap = 1'b0;
  int pos = 0, cnt = 0, m_addr = 0, m_data = 0;
  bit p_we = 0, p_done = 0, p_err = 0, p_tag = 0;
  bit e_we = 0, e_busy = 0, e_done = 0, e_err = 0, tag22 = 0;
  int e_addr = 0, e_data = 0, e_cnt = 0;
  int wlog[$];
  int n_done = 0, n_err = 0, a22 = -1;
  int b_wr, b_done, b_err;

  framebuffer_writer #(.SRC_WIDTH(W), .SRC_HEIGHT(H), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_WIDTH(17)) dut (
    .cam_clk_25(clk), .reset(reset), .enable(en), .pix_valid(pv), .pix_data(pd),
    .pix_sof(ps), .pix_eol(pe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Position is the linear index of the pixel since sof; coordinates come from it.
  task automatic model(input bit v, input bit s, input bit e, input logic [1:0] d, input bit enb);
    bit go, last, ok;
    int x, y;
    p_we = 0; p_done = 0; p_err = 0; p_tag = 0;
    if (v) begin
      go = cap;
      if (s) begin
        if (cap) p_err = 1;
        go = enb;
        if (enb) pos = 0;
        else cap = 0;
      end
      if (go) begin
        x = pos % W;
        y = pos / W;
        last = (x == W - 1);
        ok = (e == last);
        if (!ok) p_err = 1;
        p_we = (e || !last) && (x % 2 == 0) && (y % 2 == 0);
        if (p_we) begin
          m_addr = (y / 2) * FBW + x / 2;
          m_data = int'(d);
        end
        p_tag = (x == 2 && y == 2);
        if (ok && e && y == H - 1 && !p_err) begin
          p_done = 1;
          cnt = (cnt + 1) % 256;
        end
        cap = ok && !(e && y == H - 1);
        pos++;
      end
    end
  endtask

  task automatic model_reset();
    cap = 0; pos = 0; cnt = 0; m_addr = 0; m_data = 0;
    p_we = 0; p_done = 0; p_err = 0; p_tag = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0; e_cnt = 0; tag22 = 0;
  endtask

  task automatic tick(input bit v, input logic [1:0] d, input bit s, input bit e);
    @(posedge clk);
    #1;
    e_we = p_we; e_addr = m_addr; e_data = m_data; e_busy = cap;
    e_done = p_done; e_err = p_err; e_cnt = cnt; tag22 = p_tag;
    pv = v; pd = d; ps = s; pe = e;
    model(v, s, e, d, en);
  endtask

  task automatic send(input logic [1:0] d, input bit s, input bit e, input int gap);
    while ($urandom_range(99) < gap) tick(0, 2'd0, 0, 0);
    tick(1, d, s, e);
  endtask

  // Sends raster pixels 0..n-1 of a frame; short_y/short_x puts an early eol,
  // long_y drops the eol of that line; both end the frame at the faulty pixel.
  task automatic frame_part(input int n, input int short_y, input int short_x,
                            input int long_y, input int drop_y, input int gap);
    int x, y;
    bit eol;
    logic [1:0] d;
    for (int p = 0; p < n; p++) begin
      x = p % W;
      y = p / W;
      if (y == drop_y && x == 0) en = 1'b0;
      eol = (x == W - 1 && y != long_y) || (y == short_y && x == short_x);
      d = 2'(((x >> 1) & 3) ^ ((y >> 1) & 3));
      send(d, p == 0, eol, gap);
      if ((y == short_y && x == short_x) || (y == long_y && x == W - 1)) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'd0, 0, 0);
  endtask

  task automatic do_reset();
    chkon = 1'b0;
    reset = 1'b1;
    pv = 0; ps = 0; pe = 0; pd = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chkon = 1'b1;
  endtask

  task automatic snap();
    b_wr = wlog.size(); b_done = n_done; b_err = n_err;
  endtask

  always @(negedge clk) begin
    if (chkon && !reset) begin
      chk("wr_en", int'(wr_en), int'(e_we));
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
      chk("busy", int'(busy), int'(e_busy));
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("frame_err", int'(frame_err), int'(e_err));
      chk("frame_count", int'(frame_count), e_cnt);
      if (wr_en) begin
        wlog.push_back(int'(wr_addr));
        if (tag22) a22 = int'(wr_addr);
      end
      n_done += int'(frame_done);
      n_err += int'(frame_err);
    end
  end

  initial begin
    #2;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(frame_count), 0);
    do_reset();
    en = 1'b1;
    // clean frame, continuous valid
    snap();
    frame_part(W * H, -1, -1, -1, -1, 0);
    idle(3);
    chk("clean_writes", wlog.size() - b_wr, FBW * FBH);
    chk("clean_first_addr", wlog[b_wr], 0);
    chk("clean_last_addr", wlog[wlog.size() - 1], FBW * FBH - 1);
    chk("clean_addr_2_2", a22, FBW + 1);
    chk("clean_done", n_done - b_done, 1);
    chk("clean_err", n_err - b_err, 0);
    chk("clean_count", int'(frame_count), 1);
    // same frame with gaps
    snap();
    frame_part(W * H, -1, -1, -1, -1, 30);
    idle(3);
    chk("gap_writes", wlog.size() - b_wr, FBW * FBH);
    chk("gap_last_addr", wlog[wlog.size() - 1], FBW * FBH - 1);
    chk("gap_done", n_done - b_done, 1);
    chk("gap_count", int'(frame_count), 2);
    // short line 5, junk, then good frame
    do_reset();
    en = 1'b1;
    snap();
    frame_part(W * H, 5, 10, -1, -1, 0);
    for (int i = 0; i < 20; i++) tick(1, 2'd3, 0, (i % 7) == 6);
    chk("short_busy", int'(busy), 0);
    chk("short_writes", wlog.size() - b_wr, 3 * FBW);
    frame_part(W * H, -1, -1, -1, -1, 0);
    idle(3);
    chk("short_err", n_err - b_err, 1);
    chk("short_done", n_done - b_done, 1);
    chk("short_after_first", wlog[b_wr + 3 * FBW], 0);
    chk("short_count", int'(frame_count), 1);
    // long line 2
    snap();
    frame_part(W * H, -1, -1, 2, -1, 0);
    idle(3);
    chk("long_err", n_err - b_err, 1);
    chk("long_writes", wlog.size() - b_wr, 2 * FBW);
    chk("long_busy", int'(busy), 0);
    // sof restart at (5,3)
    do_reset();
    en = 1'b1;
    snap();
    frame_part(3 * W + 5, -1, -1, -1, -1, 0);
    frame_part(W * H, -1, -1, -1, -1, 0);
    idle(3);
    chk("restart_err", n_err - b_err, 1);
    chk("restart_sof_addr", wlog[b_wr + 2 * FBW], 0);
    chk("restart_writes", wlog.size() - b_wr, 2 * FBW + FBW * FBH);
    chk("restart_done", n_done - b_done, 1);
    chk("restart_count", int'(frame_count), 1);
    // enable off, then on with drop mid-frame, then idle through next sof
    do_reset();
    en = 1'b0;
    snap();
    frame_part(W * H, -1, -1, -1, -1, 0);
    chk("dis_writes", wlog.size() - b_wr, 0);
    en = 1'b1;
    frame_part(W * H, -1, -1, -1, 3, 0);
    frame_part(W * H, -1, -1, -1, -1, 0);
    idle(3);
    chk("drop_writes", wlog.size() - b_wr, FBW * FBH);
    chk("drop_done", n_done - b_done, 1);
    chk("drop_count", int'(frame_count), 1);
    chk("drop_busy", int'(busy), 0);
    // reset during write cycle of pixel (6,8)
    do_reset();
    en = 1'b1;
    frame_part(8 * W + 7, -1, -1, -1, -1, 0);
    chkon = 1'b0;
    @(posedge clk);
    #1;
    pv = 0; ps = 0; pe = 0;
    chk("mid_wr_en_before", int'(wr_en), 1);
    chk("mid_addr_before", int'(wr_addr), 4 * FBW + 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_wr_en", int'(wr_en), 0);
    chk("mid_addr", int'(wr_addr), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_count", int'(frame_count), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chkon = 1'b1;
    snap();
    frame_part(W * H, -1, -1, -1, -1, 0);
    idle(3);
    chk("post_first_addr", wlog[b_wr], 0);
    chk("post_writes", wlog.size() - b_wr, FBW * FBH);
    chk("post_count", int'(frame_count), 1);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
